// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the mips_cpu datapath.
// Sequences each instruction through fetch, decode, execute, memory and write-back.
// It drives the ALU operand muxes and select, and runs the memory req/ready handshake.
// It raises overflow, illegal-instruction and memory-timeout exceptions.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_opcode/i_funct/i_rt_field IR fields, valid from DECODE onward
//   i_alu_zero/ge/overflow     ALU flags
//   i_mem_ready                memory completes the current request this cycle
//   o_mem_req/we, o_iord       memory request, write, address select (1 = ALUOut)
//   o_ir_write, o_pc_write, o_pc_src   IR/PC load controls
//   o_alu_src_a/b, o_alu_sel, o_ext_sel ALU operand/function controls
//   o_reg_write, o_reg_dst, o_mem_to_reg register-file write controls
//   o_exc_valid, o_exc_cause   one-cycle exception pulse and cause
//   o_state                    current state (debug)
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt_field,
    input  logic       i_alu_zero,
    input  logic       i_alu_ge,
    input  logic       i_alu_overflow,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_iord,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic [1:0] o_pc_src,
    output logic       o_alu_src_a,
    output logic [2:0] o_alu_src_b,
    output logic [2:0] o_alu_sel,
    output logic       o_ext_sel,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_exc_valid,
    output logic [1:0] o_exc_cause,
    output logic [3:0] o_state
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;
    localparam logic [2:0] ALU_SAR = 3'd4;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ovf;
    logic [1:0]        r_cause;
    logic [WAIT_W-1:0] r_wait;
    logic              w_set_cause;
    logic [1:0]        w_new_cause;

    // Instruction classification from the IR fields
    logic w_is_rtype, w_is_itype, w_is_beq, w_is_bgez, w_timeout;
    assign w_is_rtype = (i_opcode == OP_RTYPE) &&
                        (i_funct == FN_ADD || i_funct == FN_ADDU || i_funct == FN_SUBU ||
                         i_funct == FN_OR  || i_funct == FN_SLT  || i_funct == FN_SRAV);
    assign w_is_itype = (i_opcode == OP_ADDI) || (i_opcode == OP_ADDIU) || (i_opcode == OP_ORI);
    assign w_is_beq   = (i_opcode == OP_BEQ);
    assign w_is_bgez  = (i_opcode == OP_REGIMM) && (i_rt_field == 5'b00001);

    // Timeout fires only on the last allowed wait cycle; a same-cycle ready wins
    assign w_timeout = (MEM_WAIT_MAX != 0) && !i_mem_ready && (r_wait == WAIT_LAST);

    assign o_state = r_state;

    // State register, overflow latch, exception cause and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ovf   <= 1'b0;
            r_cause <= 2'd0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC_R)
                r_ovf <= (i_funct == FN_ADD) && i_alu_overflow;
            else if (r_state == S_EXEC_I)
                r_ovf <= (i_opcode == OP_ADDI) && i_alu_overflow;
            if (w_set_cause)
                r_cause <= w_new_cause;
            // Counter restarts whenever a state is entered
            if (w_next != r_state)
                r_wait <= '0;
            else
                r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next       = r_state;
        w_set_cause  = 1'b0;
        w_new_cause  = 2'd0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 2'b00;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 3'b000;
        o_alu_sel    = ALU_ADD;
        o_ext_sel    = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_exc_valid  = 1'b0;
        o_exc_cause  = 2'd0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = 3'b001;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_set_cause = 1'b1;
                    w_new_cause = 2'd3;
                end
            end
            S_DECODE: begin
                o_alu_src_b = 3'b011;
                o_ext_sel   = 1'b1;
                if (w_is_rtype)                                   w_next = S_EXEC_R;
                else if (w_is_itype)                              w_next = S_EXEC_I;
                else if (i_opcode == OP_LW || i_opcode == OP_SW)  w_next = S_MEM_ADDR;
                else if (w_is_beq || w_is_bgez)                   w_next = S_BRANCH;
                else if (i_opcode == OP_J)                        w_next = S_JUMP;
                else begin
                    w_next      = S_TRAP;
                    w_set_cause = 1'b1;
                    w_new_cause = 2'd2;
                end
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                case (i_funct)
                    FN_SUBU: o_alu_sel = ALU_SUB;
                    FN_OR:   o_alu_sel = ALU_OR;
                    FN_SLT:  o_alu_sel = ALU_SLT;
                    FN_SRAV: o_alu_sel = ALU_SAR;
                    default: o_alu_sel = ALU_ADD;
                endcase
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 3'b010;
                if (i_opcode == OP_ORI) begin
                    o_alu_sel = ALU_OR;
                end else begin
                    o_ext_sel = 1'b1;
                end
                w_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                if (r_ovf) begin
                    w_next      = S_TRAP;
                    w_set_cause = 1'b1;
                    w_new_cause = 2'd1;
                end else begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = (i_opcode == OP_RTYPE);
                    w_next      = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 3'b010;
                o_ext_sel   = 1'b1;
                w_next      = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                o_mem_we  = (r_state == S_MEM_WR);
                if (i_mem_ready) begin
                    w_next = (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_set_cause = 1'b1;
                    w_new_cause = 2'd3;
                end
            end
            S_WB_MEM: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_pc_src    = 2'b01;
                if (w_is_beq) begin
                    o_alu_sel  = ALU_SUB;
                    o_pc_write = i_alu_zero;
                end else begin
                    o_alu_src_b = 3'b100;
                    o_pc_write  = i_alu_ge;
                end
                w_next = S_FETCH;
            end
            S_JUMP: begin
                o_pc_write = 1'b1;
                o_pc_src   = 2'b10;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                o_exc_valid = 1'b1;
                o_exc_cause = r_cause;
                o_pc_write  = 1'b1;
                o_pc_src    = 2'b11;
                w_next      = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus randomized instruction stream checked cycle by
// cycle against an instruction-level reference model of the control sequencing.
module tb_multicycle_ctrl;

    localparam int WAIT_N = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       a;
        logic [2:0] b;
        logic [2:0] sel;
        logic       ext, rw, rdst, m2r, exc_v;
        logic [1:0] exc_c;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic [4:0] rt_field = '0;
    logic       alu_zero = 1'b0, alu_ge = 1'b0, alu_overflow = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, ext_sel;
    logic       reg_write, reg_dst, mem_to_reg, exc_valid;
    logic [1:0] pc_src, exc_cause;
    logic [2:0] alu_src_b, alu_sel;
    logic [3:0] state_o;

    int n_assert = 0;
    int n_fail   = 0;
    int f_z = -1, f_ge = -1, f_ov = -1;   // -1 = random, else forced value

    multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_N)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_opcode(opcode), .i_funct(funct), .i_rt_field(rt_field),
        .i_alu_zero(alu_zero), .i_alu_ge(alu_ge), .i_alu_overflow(alu_overflow),
        .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord),
        .o_ir_write(ir_write), .o_pc_write(pc_write), .o_pc_src(pc_src),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_sel(alu_sel),
        .o_ext_sel(ext_sel), .o_reg_write(reg_write), .o_reg_dst(reg_dst),
        .o_mem_to_reg(mem_to_reg), .o_exc_valid(exc_valid), .o_exc_cause(exc_cause),
        .o_state(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input int st);
        obs_t e;
        e = '0;
        e.st = 4'(st);
        return e;
    endfunction

    // 0 illegal, 1 R-type ALU, 2 I-type ALU, 3 lw, 4 sw, 5 beq, 6 bgez, 7 j
    function automatic int cls(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
        if (op == 6'b000000)
            return (fn == 6'b100000 || fn == 6'b100001 || fn == 6'b100011 ||
                    fn == 6'b100101 || fn == 6'b101010 || fn == 6'b000111) ? 1 : 0;
        if (op == 6'b001000 || op == 6'b001001 || op == 6'b001101) return 2;
        if (op == 6'b100011) return 3;
        if (op == 6'b101011) return 4;
        if (op == 6'b000100) return 5;
        if (op == 6'b000001 && rt == 5'b00001) return 6;
        if (op == 6'b000010) return 7;
        return 0;
    endfunction

    function automatic logic [2:0] r_sel(input logic [5:0] fn);
        case (fn)
            6'b100011: return 3'd1;
            6'b100101: return 3'd2;
            6'b101010: return 3'd3;
            6'b000111: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    // Fresh per-cycle flag/ready values (forced where requested)
    task automatic drive();
        alu_zero     = (f_z  < 0) ? 1'($urandom) : 1'(f_z);
        alu_ge       = (f_ge < 0) ? 1'($urandom) : 1'(f_ge);
        alu_overflow = (f_ov < 0) ? 1'($urandom) : 1'(f_ov);
        mem_ready    = 1'($urandom);
    endtask

    // Inputs were driven at the falling edge; sample 1 time unit later, then advance a cycle
    task automatic check(input string tag, input obs_t e);
        obs_t o;
        #1;
        o.st = state_o; o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord;
        o.ir_write = ir_write; o.pc_write = pc_write; o.pc_src = pc_src;
        o.a = alu_src_a; o.b = alu_src_b; o.sel = alu_sel; o.ext = ext_sel;
        o.rw = reg_write; o.rdst = reg_dst; o.m2r = mem_to_reg;
        o.exc_v = exc_valid; o.exc_c = exc_cause;
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic trap(input int cause);
        obs_t e;
        drive();
        e = mk(12); e.exc_v = 1'b1; e.exc_c = 2'(cause); e.pc_write = 1'b1; e.pc_src = 2'b11;
        check("trap", e);
    endtask

    // A memory wait state: ready arrives after 'waits' idle cycles unless the timeout hits first
    task automatic wait_phase(input int st, input int waits, output bit timed_out);
        obs_t e;
        timed_out = 1'b0;
        for (int i = 0; i < WAIT_N; i++) begin
            drive();
            mem_ready = (i == waits);
            e = mk(st); e.mem_req = 1'b1; e.iord = (st != 1); e.mem_we = (st == 7);
            if (st == 1) begin
                e.b = 3'b001;
                if (mem_ready) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            end
            check(st == 1 ? "fetch" : "mem_wait", e);
            if (mem_ready) return;
        end
        timed_out = 1'b1;
    endtask

    task automatic wb_alu(input bit ovf, input bit is_r);
        obs_t e;
        drive();
        e = mk(9);
        if (!ovf) begin e.rw = 1'b1; e.rdst = is_r; end
        check("wb_alu", e);
        if (ovf) trap(1);
    endtask

    // Reference model of one instruction from fetch to its last state
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                             input int fw, input int mw);
        obs_t e;
        bit   to;
        bit   ovf;
        int   k;
        opcode = 6'($urandom); funct = 6'($urandom); rt_field = 5'($urandom);
        wait_phase(1, fw, to);
        if (to) begin trap(3); return; end
        opcode = op; funct = fn; rt_field = rt;
        drive();
        e = mk(2); e.b = 3'b011; e.ext = 1'b1;
        check("decode", e);
        k = cls(op, fn, rt);
        drive();
        case (k)
            1: begin
                ovf = (fn == 6'b100000) && alu_overflow;
                e = mk(3); e.a = 1'b1; e.sel = r_sel(fn);
                check("exec_r", e);
                wb_alu(ovf, 1'b1);
            end
            2: begin
                ovf = (op == 6'b001000) && alu_overflow;
                e = mk(4); e.a = 1'b1; e.b = 3'b010;
                if (op == 6'b001101) e.sel = 3'd2; else e.ext = 1'b1;
                check("exec_i", e);
                wb_alu(ovf, 1'b0);
            end
            3, 4: begin
                e = mk(5); e.a = 1'b1; e.b = 3'b010; e.ext = 1'b1;
                check("mem_addr", e);
                wait_phase(k == 3 ? 6 : 7, mw, to);
                if (to) trap(3);
                else if (k == 3) begin
                    drive();
                    e = mk(8); e.rw = 1'b1; e.m2r = 1'b1;
                    check("wb_mem", e);
                end
            end
            5, 6: begin
                e = mk(10); e.a = 1'b1; e.pc_src = 2'b01;
                if (k == 5) begin e.sel = 3'd1; e.pc_write = alu_zero; end
                else begin e.b = 3'b100; e.pc_write = alu_ge; end
                check(k == 5 ? "beq" : "bgez", e);
            end
            7: begin
                e = mk(11); e.pc_write = 1'b1; e.pc_src = 2'b10;
                check("jump", e);
            end
            default: trap(2);
        endcase
    endtask

    initial begin
        obs_t e;
        bit   to;
        int   r;
        logic [5:0] op, fn;
        logic [4:0] rt;
        logic [5:0] rfn [6];
        rfn = '{6'b100000, 6'b100001, 6'b100011, 6'b100101, 6'b101010, 6'b000111};

        // Reset: held low, then one IDLE cycle after release
        repeat (2) @(negedge clk);
        drive();
        check("reset_hold", mk(0));
        rst_n = 1'b1;
        drive();
        check("idle", mk(0));

        // Directed: addu ignores overflow, add traps with cause 1
        f_ov = 1;
        run_instr(6'b000000, 6'b100001, 5'd0, 0, 0);
        run_instr(6'b000000, 6'b100000, 5'd0, 0, 0);
        run_instr(6'b001001, 6'd0, 5'd0, 0, 0);
        run_instr(6'b001000, 6'd0, 5'd0, 0, 0);
        f_ov = -1;
        // lw with three wait cycles, sw with ready in the timeout cycle
        run_instr(6'b100011, 6'd0, 5'd0, 0, 3);
        run_instr(6'b101011, 6'd0, 5'd0, 0, WAIT_N - 1);
        // Branches with forced flags
        f_ge = 1; run_instr(6'b000001, 6'd0, 5'b00001, 0, 0);
        f_ge = 0; run_instr(6'b000001, 6'd0, 5'b00001, 0, 0);
        f_ge = -1;
        f_z = 1;  run_instr(6'b000100, 6'd0, 5'd0, 0, 0);
        f_z = 0;  run_instr(6'b000100, 6'd0, 5'd0, 0, 0);
        f_z = -1;
        run_instr(6'b000010, 6'd0, 5'd0, 0, 0);
        // Illegal opcode and REGIMM with another rt
        run_instr(6'b111111, 6'd0, 5'd0, 0, 0);
        run_instr(6'b000001, 6'd0, 5'b00000, 0, 0);
        // Fetch timeout and read timeout
        run_instr(6'b000000, 6'b100101, 5'd0, WAIT_N, 0);
        run_instr(6'b100011, 6'd0, 5'd0, 0, WAIT_N + 1);

        // Reset asserted in MEM_WR aborts at once
        wait_phase(1, 0, to);
        opcode = 6'b101011;
        drive();
        e = mk(2); e.b = 3'b011; e.ext = 1'b1;
        check("decode_sw", e);
        drive();
        e = mk(5); e.a = 1'b1; e.b = 3'b010; e.ext = 1'b1;
        check("mem_addr_sw", e);
        drive(); mem_ready = 1'b0;
        e = mk(7); e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
        check("mem_wr", e);
        drive(); mem_ready = 1'b0;
        rst_n = 1'b0;
        check("rst_abort", mk(0));
        drive();
        check("rst_abort_hold", mk(0));
        rst_n = 1'b1;
        drive();
        check("idle_again", mk(0));

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 9));
            fn = 6'($urandom);
            rt = 5'($urandom);
            case (r)
                0: begin op = 6'b000000; if ($urandom_range(0, 3) != 0) fn = rfn[$urandom_range(0, 5)]; end
                1: op = 6'b001000;
                2: op = 6'b001001;
                3: op = 6'b001101;
                4: op = 6'b100011;
                5: op = 6'b101011;
                6: op = 6'b000100;
                7: begin op = 6'b000001; if ($urandom_range(0, 1) != 0) rt = 5'b00001; end
                8: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, rt,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT_N + 1)) : 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT_N + 1)) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
